// File: rtl/float_add_sequencer_pkg.sv
// Shared widths and FSM state encoding for float_add_sequencer and its benches.
// The optional error counter is enabled by defining FADD_SEQ_ERRCNT_EN.
package fadd_seq_defs;

    localparam int FADD_ADDR_W = 5;
    localparam int FADD_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_EXEC = 3'd3,
        ST_WR   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

endpackage

// File: rtl/float_add_sequencer_adder.sv
// float_adder: combinational IEEE-754 single-precision add, round-to-nearest-even,
// with subnormal, infinity and NaN handling.
module float_adder
    import fadd_seq_defs::*;
(
    input  logic [FADD_DATA_W-1:0] a,
    input  logic [FADD_DATA_W-1:0] b,
    output logic [FADD_DATA_W-1:0] sum
);

    logic        a_nan, b_nan, a_inf, b_inf, swap;
    logic        big_s, sml_s;
    logic [7:0]  big_e, sml_e, exp_diff;
    logic [23:0] big_m, sml_m;
    logic [4:0]  shamt;
    logic [53:0] sml_ext;
    logic [26:0] big_al, sml_al, norm;
    logic [27:0] raw;
    logic [4:0]  lz;
    logic        lz_found;
    logic [9:0]  exp_n, sh;
    logic        round_up;
    logic [24:0] mant_r;

    always_comb begin
        a_nan = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);

        swap  = b[30:0] > a[30:0];
        big_s = swap ? b[31] : a[31];
        sml_s = swap ? a[31] : b[31];
        big_e = swap ? b[30:23] : a[30:23];
        sml_e = swap ? a[30:23] : b[30:23];
        big_m = {big_e != 8'd0, swap ? b[22:0] : a[22:0]};
        sml_m = {sml_e != 8'd0, swap ? a[22:0] : b[22:0]};

        // Subnormals behave as exponent 1 with a zero hidden bit.
        exp_diff = (big_e == 8'd0 ? 8'd1 : big_e) - (sml_e == 8'd0 ? 8'd1 : sml_e);
        shamt    = (exp_diff > 8'd31) ? 5'd31 : exp_diff[4:0];
        sml_ext  = {sml_m, 3'b000, 27'd0} >> shamt;
        sml_al   = {sml_ext[53:28], sml_ext[27] | (|sml_ext[26:0])};
        big_al   = {big_m, 3'b000};

        if (big_s == sml_s) begin
            raw = {1'b0, big_al} + {1'b0, sml_al};
        end else begin
            raw = {1'b0, big_al} - {1'b0, sml_al};
        end

        lz       = 5'd0;
        lz_found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!lz_found) begin
                if (raw[i]) begin
                    lz_found = 1'b1;
                end else begin
                    lz = lz + 5'd1;
                end
            end
        end

        exp_n = {2'b00, (big_e == 8'd0) ? 8'd1 : big_e};
        sh    = 10'd0;
        if (raw[27]) begin
            norm  = {raw[27:2], raw[1] | raw[0]};
            exp_n = exp_n + 10'd1;
        end else begin
            // Left shift stops at exponent 1 so tiny results stay subnormal.
            sh    = ({5'd0, lz} < exp_n) ? {5'd0, lz} : exp_n - 10'd1;
            norm  = raw[26:0] << sh;
            exp_n = exp_n - sh;
        end

        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r   = {1'b0, norm[26:3]} + {24'd0, round_up};
        if (mant_r[24]) begin
            mant_r = mant_r >> 1;
            exp_n  = exp_n + 10'd1;
        end

        if (a_nan) begin
            sum = a | 32'h0040_0000;
        end else if (b_nan) begin
            sum = b | 32'h0040_0000;
        end else if (a_inf && b_inf && (a[31] != b[31])) begin
            sum = 32'h7fc0_0000;
        end else if (a_inf) begin
            sum = a;
        end else if (b_inf) begin
            sum = b;
        end else if (raw == 28'd0) begin
            sum = {a[31] & b[31], 31'd0};
        end else if (exp_n >= 10'd255) begin
            sum = {big_s, 8'hff, 23'd0};
        end else begin
            sum = {big_s, mant_r[23] ? exp_n[7:0] : 8'd0, mant_r[22:0]};
        end
    end

endmodule

// File: rtl/float_add_sequencer.sv
// float_add_sequencer: reads A/B/expected per element, adds via float_adder, writes and checks sums.
// Define FADD_SEQ_ERRCNT_EN to build the saturating err_cnt output.
module float_add_sequencer
    import fadd_seq_defs::*;
#(
    parameter int ADDR_W = FADD_ADDR_W,
    parameter int DATA_W = FADD_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    input  logic [DATA_W-1:0] e_data,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic [DATA_W-1:0] res_data
`ifdef FADD_SEQ_ERRCNT_EN
    ,
    output logic [ADDR_W:0]   err_cnt
`endif
);

    localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, op_e_q, op_e_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [DATA_W-1:0] sum;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic              rd_en_q, rd_en_d, res_we_q, res_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, res_addr_q, res_addr_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
`ifdef FADD_SEQ_ERRCNT_EN
    logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
`endif

    float_adder u_adder (
        .a   (op_a_q),
        .b   (op_b_q),
        .sum (sum)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_e_d      = op_e_q;
        exp_d       = exp_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        rd_en_d     = 1'b0;
        res_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        res_addr_d  = res_addr_q;
        res_data_d  = res_data_q;
`ifdef FADD_SEQ_ERRCNT_EN
        err_cnt_d   = err_cnt_q;
`endif

        // Outputs are computed one state ahead so every port comes straight from a flop.
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ptr_d       = base_addr;
                    remaining_d = (count > MAX_CNT) ? MAX_CNT : count;
                    pass_d      = 1'b1;
                    busy_d      = 1'b1;
`ifdef FADD_SEQ_ERRCNT_EN
                    err_cnt_d   = '0;
`endif
                    if (count == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = ST_RD;
                        rd_en_d    = 1'b1;
                        mem_addr_d = base_addr;
                    end
                end
            end
            ST_RD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                op_a_d  = a_data;
                op_b_d  = b_data;
                op_e_d  = e_data;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                res_data_d = sum;
                exp_d      = op_e_q;
                res_we_d   = 1'b1;
                res_addr_d = ptr_q;
                state_d    = ST_WR;
            end
            ST_WR: begin
                if (res_data_q != exp_q) begin
                    pass_d = 1'b0;
`ifdef FADD_SEQ_ERRCNT_EN
                    if (err_cnt_q != MAX_CNT) begin
                        err_cnt_d = err_cnt_q + (ADDR_W+1)'(1);
                    end
`endif
                end
                ptr_d       = ptr_q + ADDR_W'(1);
                remaining_d = remaining_q - (ADDR_W+1)'(1);
                if (remaining_q == (ADDR_W+1)'(1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d    = ST_RD;
                    rd_en_d    = 1'b1;
                    mem_addr_d = ptr_q + ADDR_W'(1);
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_e_q      <= '0;
            exp_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            res_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            res_addr_q  <= '0;
            res_data_q  <= '0;
`ifdef FADD_SEQ_ERRCNT_EN
            err_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_e_q      <= op_e_d;
            exp_q       <= exp_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            rd_en_q     <= rd_en_d;
            res_we_q    <= res_we_d;
            mem_addr_q  <= mem_addr_d;
            res_addr_q  <= res_addr_d;
            res_data_q  <= res_data_d;
`ifdef FADD_SEQ_ERRCNT_EN
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign rd_en    = rd_en_q;
    assign res_we   = res_we_q;
    assign mem_addr = mem_addr_q;
    assign res_addr = res_addr_q;
    assign res_data = res_data_q;
`ifdef FADD_SEQ_ERRCNT_EN
    assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_float_add_sequencer.sv
// Self-checking bench for float_add_sequencer: memory model, write scoreboard, vector table
// and hand-built multi-cycle sequences (wrap, zero count, busy collision, reset, clamping).
`timescale 1ns/1ps
module tb_float_add_sequencer;
    import fadd_seq_defs::*;

    localparam int AW = FADD_ADDR_W;
    localparam int DW = FADD_DATA_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          busy, done, pass, rd_en, res_we;
    logic [AW-1:0] mem_addr, res_addr;
    logic [DW-1:0] a_data = '0;
    logic [DW-1:0] b_data = '0;
    logic [DW-1:0] e_data = '0;
    logic [DW-1:0] res_data;
`ifdef FADD_SEQ_ERRCNT_EN
    logic [AW:0]   err_cnt;
`endif

    float_add_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .mem_addr  (mem_addr),
        .rd_en     (rd_en),
        .a_data    (a_data),
        .b_data    (b_data),
        .e_data    (e_data),
        .res_we    (res_we),
        .res_addr  (res_addr),
        .res_data  (res_data)
`ifdef FADD_SEQ_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] a_mem [32];
    logic [31:0] b_mem [32];
    logic [31:0] e_mem [32];
    logic [31:0] sum_mem [32];

    // Synchronous-read memories: data appears the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= a_mem[mem_addr];
            b_data <= b_mem[mem_addr];
            e_data <= e_mem[mem_addr];
        end
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            when;
    } wr_t;

    typedef struct {
        int          base;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        logic [31:0] sum;
        bit          pass;
    } vec_t;

    wr_t  wr_q[$];
    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;
    int   rd_cnt = 0;
    bit   exp_pass_m;
    int   exp_err_m;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one cycle and observe reads and result writes against the scoreboard.
    task automatic tick();
        wr_t w;
        @(negedge clk);
        if (rd_en) rd_cnt++;
        if (res_we) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got write to %0d at cycle %0d expected none",
                         res_addr, cyc);
            end else begin
                w = wr_q.pop_front();
                checkOutput("wr_addr", 32'(res_addr), 32'(w.addr));
                checkOutput("wr_data", res_data, w.data);
                checkOutput("wr_cycle", cyc, w.when);
            end
        end
    endtask

    task automatic loadElem(input int addr, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] e, input logic [31:0] s);
        a_mem[addr]   = a;
        b_mem[addr]   = b;
        e_mem[addr]   = e;
        sum_mem[addr] = s;
    endtask

    task automatic applyStimulus(input int base, input int cnt, output int t0);
        int n;
        int addr;
        wr_t w;
        n          = (cnt > 32) ? 32 : cnt;
        base_addr  = AW'(base);
        count      = (AW+1)'(cnt);
        start      = 1'b1;
        t0         = cyc;
        rd_cnt     = 0;
        exp_pass_m = 1'b1;
        exp_err_m  = 0;
        for (int i = 0; i < n; i++) begin
            addr   = (base + i) % 32;
            w.addr = AW'(addr);
            w.data = sum_mem[addr];
            w.when = t0 + 4 + 4 * i;
            wr_q.push_back(w);
            if (sum_mem[addr] !== e_mem[addr]) begin
                exp_pass_m = 1'b0;
                exp_err_m++;
            end
        end
        tick();
        start = 1'b0;
        checkOutput("busy_rise", 32'(busy), 32'd1);
    endtask

    task automatic waitDone(input int t0, input int cnt, input bit exp_pass, input int exp_err);
        int n;
        int budget;
        n      = (cnt > 32) ? 32 : cnt;
        budget = 0;
        while (!done && budget < 200) begin
            tick();
            budget++;
        end
        checkOutput("done_seen", 32'(done), 32'd1);
        if (done) begin
            checkOutput("done_cycle", cyc, t0 + 1 + 4 * n);
            checkOutput("pass", 32'(pass), 32'(exp_pass));
`ifdef FADD_SEQ_ERRCNT_EN
            checkOutput("err_cnt", 32'(err_cnt), exp_err);
`endif
            checkOutput("busy_at_done", 32'(busy), 32'd1);
            checkOutput("rd_count", rd_cnt, n);
            checkOutput("writes_left", wr_q.size(), 32'd0);
            tick();
            checkOutput("busy_fall", 32'(busy), 32'd0);
            checkOutput("done_pulse", 32'(done), 32'd0);
            checkOutput("pass_hold", 32'(pass), 32'(exp_pass));
        end
        wr_q.delete();
    endtask

    task automatic checkResetState();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_pass", 32'(pass), 32'd0);
        checkOutput("rst_rd_en", 32'(rd_en), 32'd0);
        checkOutput("rst_res_we", 32'(res_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_res_addr", 32'(res_addr), 32'd0);
        checkOutput("rst_res_data", res_data, 32'd0);
`ifdef FADD_SEQ_ERRCNT_EN
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    endtask

    initial begin
        int t0;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        count     = '0;
        for (int i = 0; i < 32; i++) begin
            loadElem(i, 32'h3f80_0000, 32'h3f80_0000, 32'h4000_0000, 32'h4000_0000);
        end

        vecs[0] = '{2,  32'h3f80_0000, 32'h3f80_0000, 32'h4000_0000, 32'h4000_0000, 1'b1};
        vecs[1] = '{2,  32'h3f80_0000, 32'h3f80_0000, 32'h4000_0001, 32'h4000_0000, 1'b0};
        vecs[2] = '{7,  32'h3fc0_0000, 32'h4010_0000, 32'h4070_0000, 32'h4070_0000, 1'b1};
        vecs[3] = '{9,  32'h3f80_0000, 32'hbf80_0000, 32'h8000_0000, 32'h0000_0000, 1'b0};
        vecs[4] = '{31, 32'h4000_0000, 32'hbf00_0000, 32'h3fc0_0000, 32'h3fc0_0000, 1'b1};
        vecs[5] = '{12, 32'h7fc0_0000, 32'h3f80_0000, 32'h7fc0_0000, 32'h7fc0_0000, 1'b1};
        vecs[6] = '{14, 32'h7f80_0000, 32'h3f80_0000, 32'h7f80_0000, 32'h7f80_0000, 1'b1};
        vecs[7] = '{16, 32'h3f80_0000, 32'h3380_0000, 32'h3f80_0000, 32'h3f80_0000, 1'b1};
        vecs[8] = '{18, 32'h7f7f_ffff, 32'h7f7f_ffff, 32'h7f80_0000, 32'h7f80_0000, 1'b1};

        repeat (3) tick();
        checkResetState();
        rst = 1'b0;
        tick();

        $display("[TB] single-element vector table");
        for (int v = 0; v < 9; v++) begin
            loadElem(vecs[v].base, vecs[v].a, vecs[v].b, vecs[v].e, vecs[v].sum);
            applyStimulus(vecs[v].base, 1, t0);
            waitDone(t0, 1, vecs[v].pass, vecs[v].pass ? 0 : 1);
        end

        $display("[TB] wrap-around base 30 count 4");
        loadElem(30, 32'h3fc0_0000, 32'h4010_0000, 32'h4070_0000, 32'h4070_0000);
        loadElem(0, 32'h4000_0000, 32'hbf00_0000, 32'h3fc0_0000, 32'h3fc0_0000);
        applyStimulus(30, 4, t0);
        waitDone(t0, 4, exp_pass_m, exp_err_m);

        $display("[TB] zero count");
        applyStimulus(5, 0, t0);
        waitDone(t0, 0, 1'b1, 0);

        $display("[TB] start ignored while busy");
        applyStimulus(20, 3, t0);
        while (cyc < t0 + 5) tick();
        start     = 1'b1;
        base_addr = AW'(25);
        count     = (AW+1)'(1);
        tick();
        start = 1'b0;
        waitDone(t0, 3, exp_pass_m, exp_err_m);

        $display("[TB] reset mid-batch");
        applyStimulus(0, 8, t0);
        while (cyc < t0 + 6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkResetState();
        wr_q.delete();
        repeat (12) tick();
        checkOutput("post_rst_idle_busy", 32'(busy), 32'd0);
        applyStimulus(4, 2, t0);
        waitDone(t0, 2, exp_pass_m, exp_err_m);

        $display("[TB] count above 32 is clamped");
        applyStimulus(0, 40, t0);
        waitDone(t0, 40, exp_pass_m, exp_err_m);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
